// File: rtl/cpuex_uart_pkg.sv
// Shared UART definitions for the program/data dump path.
// Holds the default bit period, the sequencer and transmitter state
// encodings, and the 8N1 frame constants.
package cpuex_uart_pkg;

  // 100 MHz core clock / 115200 baud
  localparam int CLK_PER_BIT_DEFAULT = 868;

  localparam logic UART_START     = 1'b0;
  localparam logic UART_STOP      = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/program_dumper_transmitter.sv
// transmitter: 8N1 UART serializer, the send-side mirror of the receiver.
// Ports:
//   CLK          in  sole clock
//   INITIALIZE_N in  synchronous active-low reset
//   data[7:0]    in  byte to send, captured on tx_start
//   tx_start     in  one-cycle start request, only while idle
//   tx_done      out one-cycle pulse during the last cycle of the stop bit
//   UART_TX      out serial line (registered), idles high
module transmitter
  import cpuex_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
  input  logic       CLK,
  input  logic       INITIALIZE_N,
  input  logic [7:0] data,
  input  logic       tx_start,
  output logic       tx_done,
  output logic       UART_TX
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_PER_BIT - 1);

  tx_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       line_q, line_d;
  logic       bit_end_s;

  assign bit_end_s = (cnt_q == LAST_CNT);
  assign UART_TX   = line_q;

  // Next-state, bit timing and line value for the serializer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    line_d  = line_q;
    tx_done = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (tx_start) begin
          state_d = TX_START;
          sh_d    = data;
          line_d  = UART_START;
        end else begin
          line_d  = UART_STOP;
        end
      end
      TX_START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = TX_DATA;
          bit_d   = 3'd0;
          line_d  = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
        end else begin
          cnt_d   = cnt_q + CW'(1'b1);
        end
      end
      TX_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = TX_STOP;
            line_d  = UART_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            line_d  = sh_q[0];
            sh_d    = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      TX_STOP: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
          tx_done = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
        line_d  = UART_STOP;
      end
    endcase
  end

  // Serializer state register; reset drops any frame and returns the line high.
  always_ff @(posedge CLK) begin
    if (!INITIALIZE_N) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/program_dumper.sv
// program_dumper: buffers 32-bit words from the core in a FIFO and sends
// each one as four 8N1 UART frames, most significant byte first.
// Ports:
//   CLK          in  sole clock
//   INITIALIZE_N in  synchronous active-low reset
//   word_in      in  word to send
//   word_valid   in  word_in valid; transfer when word_valid & word_ready
//   word_ready   out FIFO has room
//   busy         out FIFO non-empty or a word is still being sent
//   fifo_count   out words currently held in the FIFO
//   UART_TX      out serial line, idles high
module program_dumper
  import cpuex_uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        CLK,
  input  logic                        INITIALIZE_N,
  input  logic [31:0]                 word_in,
  input  logic                        word_valid,
  output logic                        word_ready,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        UART_TX
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            push_s, pop_s;
  logic [31:0]     head_s;

  seq_state_t      state_q, state_d;
  logic [31:0]     sh_q, sh_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            arm_q, arm_d;
  logic            tx_start_s, tx_done_s;

  assign word_ready = (count_q < CNTW'(FIFO_DEPTH));
  assign push_s     = word_valid & word_ready;
  assign head_s     = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign busy       = (count_q != '0) | (state_q != IDLE);

  // FIFO pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1'b1);
      2'b01:   count_d = count_q - CNTW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

  // Sequencer: turns each popped word into four byte frames.
  // A word landing in an empty FIFO waits one arm cycle in IDLE before the
  // pop, which puts the first start bit on the third edge after acceptance.
  // After the fourth byte a queued word is chained straight from SEND, so the
  // line sees the same single idle cycle between words as between bytes.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    byte_idx_d = byte_idx_q;
    pop_s      = 1'b0;
    tx_start_s = 1'b0;
    arm_d      = (state_q == IDLE) && (count_q != '0);
    case (state_q)
      IDLE: begin
        if (arm_q && (count_q != '0)) begin
          pop_s      = 1'b1;
          sh_d       = head_s;
          byte_idx_d = 2'd0;
          state_d    = LOAD;
        end else begin
          state_d    = IDLE;
        end
      end
      LOAD: begin
        tx_start_s = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_done_s) begin
          if (byte_idx_q == 2'd3) begin
            if (count_q != '0) begin
              pop_s      = 1'b1;
              sh_d       = head_s;
              byte_idx_d = 2'd0;
              state_d    = LOAD;
            end else begin
              state_d    = IDLE;
            end
          end else begin
            sh_d       = {sh_q[23:0], 8'h00};
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = LOAD;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO and sequencer registers; reset discards queued words and the word in flight.
  always_ff @(posedge CLK) begin
    if (!INITIALIZE_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      sh_q       <= 32'h0000_0000;
      byte_idx_q <= 2'd0;
      arm_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      sh_q       <= sh_d;
      byte_idx_q <= byte_idx_d;
      arm_q      <= arm_d;
    end
  end

  transmitter #(
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_tx (
    .CLK          (CLK),
    .INITIALIZE_N (INITIALIZE_N),
    .data         (sh_q[31:24]),
    .tx_start     (tx_start_s),
    .tx_done      (tx_done_s),
    .UART_TX      (UART_TX)
  );

endmodule

// File: tb/tb_program_dumper.sv
// Self-checking bench for program_dumper with CLK_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes frames mid-bit; vectors carry words with their
// hand-computed byte sequences.
module tb_program_dumper;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        INITIALIZE_N = 1'b0;
  logic [31:0] word_in = 32'h0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        UART_TX;

  program_dumper #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .INITIALIZE_N (INITIALIZE_N),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .UART_TX      (UART_TX)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int first_acc = 0;
  int idle_cyc  = 0;
  bit saw_full  = 1'b0;
  int cnt_exp [5] = '{1, 2, 2, 3, 4};

  int         st_q [$];
  logic [7:0] rx_q [$];
  logic [9:0] fr_q [$];

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;
  vec_t vec [19];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Line monitor: start detected at first low negedge, bits sampled mid-bit.
  initial begin
    logic [9:0] fr;
    forever begin
      @(negedge CLK);
      if (INITIALIZE_N === 1'b1 && UART_TX === 1'b0) begin
        st_q.push_back(cyc);
        repeat (CPB/2) @(negedge CLK);
        fr[0] = UART_TX;
        for (int k = 1; k < 10; k++) begin
          repeat (CPB) @(negedge CLK);
          fr[k] = UART_TX;
        end
        fr_q.push_back(fr);
        rx_q.push_back(fr[8:1]);
        check("stop_bit", {31'h0, fr[9]}, 32'h1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] w, output int acc, output int cnt);
    int k;
    k = 0;
    word_in    = w;
    word_valid = 1'b1;
    while (word_ready !== 1'b1 && k < 400) begin
      saw_full = 1'b1;
      check("ready_low_count", 32'(fifo_count), 32'd4);
      @(posedge CLK); #1;
      k++;
    end
    if (k >= 400) check("push_timeout", 32'(k), 32'd0);
    @(posedge CLK); #1;
    acc = cyc;
    cnt = 32'(fifo_count);
    word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge CLK);
    while (busy !== 1'b0 && k < 8000) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 8000) check("idle_timeout", 32'(k), 32'd0);
    idle_cyc = cyc;
    repeat (4) @(negedge CLK);
  endtask

  task automatic clear_q();
    st_q.delete();
    rx_q.delete();
    fr_q.delete();
  endtask

  task automatic run_words(input int first, input int n, input bit cnt_chk);
    int acc, cnt;
    for (int j = 0; j < n; j++) begin
      push(vec[first+j].word, acc, cnt);
      if (j == 0) first_acc = acc;
      if (cnt_chk && j < 5) check($sformatf("count_after_push%0d", j), 32'(cnt), 32'(cnt_exp[j]));
    end
    wait_idle();
    check("byte_count", 32'(rx_q.size()), 32'(4*n));
    for (int j = 0; j < n; j++) begin
      if (rx_q.size() >= 4*j+4) begin
        check($sformatf("w%0d_b0", first+j), 32'(rx_q[4*j+0]), 32'(vec[first+j].b0));
        check($sformatf("w%0d_b1", first+j), 32'(rx_q[4*j+1]), 32'(vec[first+j].b1));
        check($sformatf("w%0d_b2", first+j), 32'(rx_q[4*j+2]), 32'(vec[first+j].b2));
        check($sformatf("w%0d_b3", first+j), 32'(rx_q[4*j+3]), 32'(vec[first+j].b3));
      end
    end
    for (int i = 1; i < st_q.size(); i++)
      check($sformatf("frame_spacing%0d", i), 32'(st_q[i] - st_q[i-1]), 32'(10*CPB + 1));
  endtask

  initial begin
    int lows, acc, cnt;
    vec[0]  = '{32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    vec[1]  = '{32'h01234567, 8'h01, 8'h23, 8'h45, 8'h67};
    vec[2]  = '{32'h89ABCDEF, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    vec[3]  = '{32'h13579BDF, 8'h13, 8'h57, 8'h9B, 8'hDF};
    vec[4]  = '{32'h2468ACE0, 8'h24, 8'h68, 8'hAC, 8'hE0};
    vec[5]  = '{32'hA5A55A5A, 8'hA5, 8'hA5, 8'h5A, 8'h5A};
    vec[6]  = '{32'h0F1E2D3C, 8'h0F, 8'h1E, 8'h2D, 8'h3C};
    vec[7]  = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vec[8]  = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    vec[9]  = '{32'h00010203, 8'h00, 8'h01, 8'h02, 8'h03};
    vec[10] = '{32'h04050607, 8'h04, 8'h05, 8'h06, 8'h07};
    vec[11] = '{32'h08090A0B, 8'h08, 8'h09, 8'h0A, 8'h0B};
    vec[12] = '{32'h0C0D0E0F, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    vec[13] = '{32'h10203040, 8'h10, 8'h20, 8'h30, 8'h40};
    vec[14] = '{32'h50607080, 8'h50, 8'h60, 8'h70, 8'h80};
    vec[15] = '{32'h90A0B0C0, 8'h90, 8'hA0, 8'hB0, 8'hC0};
    vec[16] = '{32'hD0E0F001, 8'hD0, 8'hE0, 8'hF0, 8'h01};
    vec[17] = '{32'hCAFEF00D, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    vec[18] = '{32'h8BADF00D, 8'h8B, 8'hAD, 8'hF0, 8'h0D};

    // 1. reset state
    INITIALIZE_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    INITIALIZE_N = 1'b1;
    check("rst_uart_tx", 32'(UART_TX), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_word_ready", 32'(word_ready), 32'd1);
    repeat (20) @(negedge CLK);
    check("rst_no_frames", 32'(st_q.size()), 32'd0);
    check("rst_line_idle", 32'(UART_TX), 32'd1);

    // 2. single word, latency, first frame bits, busy fall
    run_words(0, 1, 1'b0);
    if (st_q.size() >= 4) begin
      check("start_latency", 32'(st_q[0] - first_acc), 32'd3);
      check("busy_fall", 32'(idle_cyc - st_q[3]), 32'(10*CPB));
    end else check("frames_word0", 32'(st_q.size()), 32'd4);
    if (fr_q.size() >= 1) check("frame0_bits", 32'(fr_q[0]), 32'(10'b1110111100));
    clear_q();

    // 3. back-to-back burst with backpressure
    saw_full = 1'b0;
    run_words(1, 6, 1'b0);
    check("saw_full", 32'(saw_full), 32'd1);
    clear_q();

    // 4. all-ones then all-zeros
    run_words(7, 2, 1'b0);
    if (fr_q.size() >= 8) begin
      check("ff_frame_bits", 32'(fr_q[0]), 32'(10'b1111111110));
      check("00_frame_bits", 32'(fr_q[4]), 32'(10'b1000000000));
    end
    clear_q();

    // 5. reset during data bits of the third frame with two words queued
    for (int j = 1; j < 4; j++) push(vec[j].word, acc, cnt);
    check("pre_reset_count", 32'(cnt), 32'd2);
    lows = 0;
    while (st_q.size() < 3 && lows < 3000) begin
      @(negedge CLK);
      lows++;
    end
    check("third_frame_seen", 32'(st_q.size() >= 3), 32'd1);
    repeat (12) @(negedge CLK);
    INITIALIZE_N = 1'b0;
    @(posedge CLK); #1;
    check("midrst_uart_tx", 32'(UART_TX), 32'd1);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_word_ready", 32'(word_ready), 32'd1);
    @(negedge CLK);
    INITIALIZE_N = 1'b1;
    lows = 0;
    for (int i = 0; i < 60*CPB; i++) begin
      @(negedge CLK);
      if (UART_TX !== 1'b1) lows++;
    end
    check("after_rst_line_low_cycles", 32'(lows), 32'd0);
    check("after_rst_busy", 32'(busy), 32'd0);
    if (rx_q.size() >= 2) begin
      check("pre_rst_b0", 32'(rx_q[0]), 32'h01);
      check("pre_rst_b1", 32'(rx_q[1]), 32'h23);
    end else check("pre_rst_bytes", 32'(rx_q.size()), 32'd2);
    clear_q();

    // 6. same-cycle push/pop at count 2, pointer wrap over 10 words
    run_words(9, 10, 1'b1);
    clear_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
